// File: rtl/proj001_result_buf_if.sv
// Handshake bundle between the calculator, the result buffer and its consumer.
// The master modport is the driving side (calculator and consumer). The slave modport is the buffer.
interface proj001_result_buf_if #(
  parameter int DEPTH = 4,
  parameter int W     = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          clear_ovf;

  modport master (
    output in_valid, in_data, out_ready, clear_ovf,
    input  out_valid, out_data, count, full, empty, overflow, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, clear_ovf,
    output out_valid, out_data, count, full, empty, overflow, drop_cnt
  );
endinterface

// File: rtl/proj001_result_buf.sv
// Show-ahead result FIFO behind the calculator. The calculator cannot be stalled,
// so a write arriving while the FIFO is full is dropped and counted.
module proj001_result_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input logic                 i_clk,
  input logic                 i_rst,
  proj001_result_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_rd_ptr, r_wr_ptr;
  logic [AW:0]             r_count;
  logic                    r_ovf;
  logic [7:0]              r_drop_cnt;

  logic w_full, w_empty, w_pop, w_push, w_drop;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.out_ready;
  assign w_push  = bus.in_valid && (!w_full || w_pop);
  assign w_drop  = bus.in_valid && w_full && !w_pop;

  // The array has no reset, so its contents after reset are don't-care.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

  // When a drop and clear_ovf arrive in the same cycle, the drop takes priority.
  // The count then restarts from 1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (bus.clear_ovf)           r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (bus.clear_ovf) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.overflow  = r_ovf;
  assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_proj001_result_buf.sv
// Directed bench for proj001_result_buf: reset, ordering, wrap, overflow/clear,
// full push+pop, saturation and asynchronous reset mid-transfer.
module tb_proj001_result_buf;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  proj001_result_buf_if #(.DEPTH(4), .W(5)) bus ();

  proj001_result_buf #(.DEPTH(4), .W(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".out_valid"}, int'(bus.out_valid), 0);
    chk({tag, ".out_data"},  int'(bus.out_data),  0);
    chk({tag, ".count"},     int'(bus.count),     0);
    chk({tag, ".empty"},     int'(bus.empty),     1);
    chk({tag, ".full"},      int'(bus.full),      0);
    chk({tag, ".overflow"},  int'(bus.overflow),  0);
    chk({tag, ".drop_cnt"},  int'(bus.drop_cnt),  0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.clear_ovf = 1'b0;

    // Reset asserted mid-cycle
    #3 rst = 1'b1;
    #1 chk_reset_outs("rst_hold");
    step();
    rst = 1'b0;
    step();
    chk_reset_outs("rst_rel");

    // out_ready on an empty buffer does nothing
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_rdy.empty", int'(bus.empty), 1);
      chk("idle_rdy.data",  int'(bus.out_data), 0);
    end
    bus.out_ready = 1'b0;

    // Single result
    wr(5'h13);
    chk("single.valid", int'(bus.out_valid), 1);
    chk("single.data",  int'(bus.out_data), 'h13);
    chk("single.count", int'(bus.count), 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("single.empty", int'(bus.empty), 1);
    chk("single.data0", int'(bus.out_data), 0);

    // Fill and order. The pointers start from offset 1, so this pass wraps them.
    for (int i = 1; i <= 4; i++) wr(5'(i));
    chk("fill.full",  int'(bus.full), 1);
    chk("fill.count", int'(bus.count), 4);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("order.d%0d", i), int'(bus.out_data), i);
      step();
    end
    bus.out_ready = 1'b0;
    chk("order.empty", int'(bus.empty), 1);
    chk("order.count", int'(bus.count), 0);

    // Overflow
    for (int i = 1; i <= 4; i++) wr(5'(i));
    wr(5'h1F);
    wr(5'h1F);
    chk("ovf.flag",  int'(bus.overflow), 1);
    chk("ovf.drops", int'(bus.drop_cnt), 2);
    chk("ovf.count", int'(bus.count), 4);
    chk("ovf.head",  int'(bus.out_data), 1);
    bus.clear_ovf = 1'b1;
    step();
    bus.clear_ovf = 1'b0;
    chk("clr.flag",  int'(bus.overflow), 0);
    chk("clr.drops", int'(bus.drop_cnt), 0);
    chk("clr.count", int'(bus.count), 4);
    bus.clear_ovf = 1'b1;
    wr(5'h1F);
    bus.clear_ovf = 1'b0;
    chk("clrdrop.flag",  int'(bus.overflow), 1);
    chk("clrdrop.drops", int'(bus.drop_cnt), 1);

    // Push and pop in the same cycle while full
    bus.out_ready = 1'b1;
    wr(5'h0A);
    chk("pp.count", int'(bus.count), 4);
    chk("pp.drops", int'(bus.drop_cnt), 1);
    begin
      int exp_q[4] = '{2, 3, 4, 'h0A};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("pp.d%0d", i), int'(bus.out_data), exp_q[i]);
        step();
      end
    end
    bus.out_ready = 1'b0;
    chk("pp.empty", int'(bus.empty), 1);

    // Drop counter saturation
    for (int i = 1; i <= 4; i++) wr(5'(i));
    bus.clear_ovf = 1'b1;
    step();
    bus.clear_ovf = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 260; i++) step();
    bus.in_valid = 1'b0;
    chk("sat.drops", int'(bus.drop_cnt), 255);
    chk("sat.head",  int'(bus.out_data), 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.out_ready = 1'b0;

    // Reset mid-operation: 3 entries queued and overflow set
    wr(5'h05);
    wr(5'h06);
    wr(5'h07);
    chk("mid.count", int'(bus.count), 3);
    chk("mid.ovf",   int'(bus.overflow), 1);
    bus.in_valid  = 1'b1;
    bus.in_data   = 5'h11;
    bus.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid.valid", int'(bus.out_valid), 0);
    chk("mid.cnt0",  int'(bus.count), 0);
    chk("mid.ovf0",  int'(bus.overflow), 0);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    step();
    chk_reset_outs("mid_rel");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/proj001_result_buf.md
# proj001_result_buf

Output-side buffer for the four-operand calculator stage. It consumes the 5-bit `result` / single-cycle `valid` pair produced by the calculator and queues each result in a small show-ahead FIFO. Results are presented to the downstream consumer through a ready/valid handshake. Overflow is counted and flagged instead of stalling, because the calculator has no back-pressure input.

## Interface
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `W`, default 5: data width; matches the calculator result width.
- `clock`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: write strobe; driven by the calculator `valid`.
- `in_data`, input, W: write data; driven by the calculator `result`.
- `out_valid`, output, 1: head entry available.
- `out_data`, output, W: head entry; 0 when empty.
- `out_ready`, input, 1: consumer accepts the head entry this cycle.
- `count`, output, log2(DEPTH)+1: current occupancy, 0..DEPTH.
- `full`, output, 1: count == DEPTH.
- `empty`, output, 1: count == 0.
- `overflow`, output, 1: sticky; set when a write is dropped.
- `drop_cnt`, output, 8: number of dropped writes; saturates at 255.
- `clear_ovf`, input, 1: synchronous clear of `overflow` and `drop_cnt`.

## Operation
- Storage: DEPTH×W register array, read pointer, write pointer and occupancy counter. Pointers wrap modulo DEPTH.
- Pop condition: `out_valid & out_ready`. `out_valid` = !empty.
- Push condition: `in_valid & (!full | pop)`. A push while full succeeds only if a pop occurs in the same cycle.
- Drop condition: `in_valid & full & !pop`.
  - Data is discarded; pointers and count are unchanged.
  - `overflow` ← 1.
  - `drop_cnt` ← min(drop_cnt+1, 255).
- Count update: +1 on push only, −1 on pop only, unchanged on push+pop or on neither.
- Each cycle `in_valid` is high is one write. The calculator pulses for one cycle per result, but back-to-back highs are legal and each one is queued.
- Empty-cycle writes do not bypass: a write into an empty buffer becomes visible on `out_data` in the next cycle.
- `out_data` = array[rd_ptr] when !empty, else 0 (forced, not stale).
- `clear_ovf`:
  - Alone: next cycle `overflow` = 0 and `drop_cnt` = 0.
  - Same cycle as a drop: the drop wins, so `overflow` = 1 and `drop_cnt` = 1.
  - Does not affect FIFO contents.
- `out_ready` while empty: no effect.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers, count, `overflow` and `drop_cnt` go to 0. Array contents are don't-care.
  - Outputs while reset is asserted and after release: `out_valid`=0, `out_data`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `drop_cnt`=0.
  - Writes arriving during reset are lost.

## Timing
- Write-to-output latency: 1 cycle. A write at edge N is visible on `out_valid`/`out_data` after edge N.
- Pop takes effect at the edge where `out_valid & out_ready` is sampled high. The next entry (or 0 / empty) appears after that edge.
- `full`, `empty` and `count` are registered-state decodes and update on the same edge as pointer changes.
- No combinational path from `out_ready` or `in_valid` to `out_valid`/`out_data`. The only combinational dependence is `out_data` on the read pointer and array.
- Sustained throughput: one write and one read per cycle when not full/empty bound.
- `overflow`/`drop_cnt` update on the edge at which the drop is sampled.

## Test plan
- Reset then idle. Assert `rst` mid-cycle and release it. Required: all outputs at reset values, `empty`=1; `out_ready`=1 held for 5 cycles changes nothing.
- Single result. Pulse `in_valid` for 1 cycle with `in_data`=5'h13, `out_ready`=0. Next cycle: `out_valid`=1, `out_data`=0x13, `count`=1. Raise `out_ready` for one cycle. Then `empty`=1 and `out_data`=0.
- Fill and order. With DEPTH=4, write 0x01, 0x02, 0x03, 0x04 with no reads. Required: `full`=1, `count`=4. Then read 4 with `out_ready`=1: data returns 1, 2, 3, 4 in order, pointers wrap, `empty`=1.
- Overflow. With the buffer full, write 0x1F twice without reads. Required: contents unchanged, `overflow`=1, `drop_cnt`=2. Then `clear_ovf` for 1 cycle gives `drop_cnt`=0; `clear_ovf` coincident with a further drop gives `overflow`=1, `drop_cnt`=1.
- Full push+pop. With the buffer full holding 1..4, write 0x0A with `out_ready`=1 in the same cycle. Required: 1 popped, no drop, `count`=4. Subsequent reads give 2, 3, 4, 0x0A.
- Reset mid-operation. With 3 entries and `overflow`=1, assert `rst` while `in_valid`=1 and `out_ready`=1. Required: immediate `out_valid`=0, `count`=0, `overflow`=0, and the in-flight write is lost.
